// File: rtl/nandgame_pkg.sv
// Shared definitions for the switch/deserializer slice.
// Channel select encodings, default word width and a constant log2 helper.
// No logic; imported by the deserializer top and its channel sub-module.
package nandgame_pkg;

  // Select values used by the upstream switch stage.
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int DEFAULT_WORD_WIDTH = 16;

  // Ceiling log2, evaluated at elaboration time to size bit counters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/switch_deser_channel.sv
// One deserializer lane: packs strobed bits into a WIDTH-bit word and holds it for a valid/ready consumer.
// Latency: word valid on the cycle after its WIDTH-th accepted bit; one word per WIDTH bits at full rate.
// Backpressure: o_can_accept drops only when the final bit would overwrite an unconsumed held word.
module switch_deser_channel
  import nandgame_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WORD_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_bit_vld,
  input  logic             i_bit,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_can_accept
);

  localparam int             CW   = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_asm;
  logic [WIDTH-1:0] r_hold;
  logic             r_valid;

  logic             w_last;
  logic [CW-1:0]    w_pos;
  logic [WIDTH-1:0] w_word;
  logic             w_load;

  assign w_last = (r_cnt == LAST);
  assign w_pos  = MSB_FIRST ? (LAST - r_cnt) : r_cnt;
  assign w_load = i_bit_vld && w_last;

  // Only the last bit can be blocked, and only while the previous word is still unconsumed.
  assign o_can_accept = !(w_last && r_valid && !i_out_ready);

  assign o_out_valid = r_valid;
  assign o_out_data  = r_hold;

  // Merge the incoming bit into the partial word at its slot.
  always_comb begin
    w_word        = r_asm;
    w_word[w_pos] = i_bit;
  end

  // Bit counter, assembly and holding registers; a same-edge drain and load keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_asm   <= '0;
      r_hold  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_bit_vld) begin
        if (w_last) begin
          r_hold <= w_word;
          r_cnt  <= '0;
          r_asm  <= '0;
        end else begin
          r_asm  <= w_word;
          r_cnt  <= r_cnt + 1'b1;
        end
      end
      if (w_load) begin
        r_valid <= 1'b1;
      end else if (r_valid && i_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/switch_deserializer.sv
// Routes a strobed serial bit stream to one of two lanes by select and packs each lane into words.
// Latency: a word is valid the cycle after its WIDTH-th accepted bit; lanes drain independently.
// Backpressure: in_ready follows the selected lane only, so a stalled lane never blocks the other.
module switch_deserializer
  import nandgame_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WORD_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s,
  input  logic             d,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
);

  logic w_can0;
  logic w_can1;
  logic w_accept;
  logic w_stb0;
  logic w_stb1;

  // in_ready depends on select and lane state only, never on in_valid or d.
  assign in_ready = (s == CH1) ? w_can1 : w_can0;
  assign w_accept = in_valid && in_ready;
  assign w_stb0   = w_accept && (s == CH0);
  assign w_stb1   = w_accept && (s == CH1);

  switch_deser_channel #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_ch0 (
    .clk          (clk),
    .rst          (rst),
    .i_bit_vld    (w_stb0),
    .i_bit        (d),
    .i_out_ready  (out0_ready),
    .o_out_valid  (out0_valid),
    .o_out_data   (out0_data),
    .o_can_accept (w_can0)
  );

  switch_deser_channel #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_ch1 (
    .clk          (clk),
    .rst          (rst),
    .i_bit_vld    (w_stb1),
    .i_bit        (d),
    .i_out_ready  (out1_ready),
    .o_out_valid  (out1_valid),
    .o_out_data   (out1_data),
    .o_can_accept (w_can1)
  );

endmodule

// File: tb/tb_switch_deserializer.sv
// Bench for switch_deserializer: an LSB-first and an MSB-first instance (WIDTH=4) share one stimulus.
// Directed sequences push hand-computed words into per-lane queues; a negedge monitor pops and compares.
// Inputs are driven 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_switch_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       s;
  logic       d;
  logic       out0_ready;
  logic       out1_ready;

  logic       in_ready_l, in_ready_m;
  logic       o0v_l, o1v_l, o0v_m, o1v_m;
  logic [3:0] o0d_l, o1d_l, o0d_m, o1d_m;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] q0l[$];
  logic [3:0] q1l[$];
  logic [3:0] q0m[$];
  logic [3:0] q1m[$];

  always #5 clk = ~clk;

  switch_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .s(s), .d(d),
    .out0_valid(o0v_l), .out0_ready(out0_ready), .out0_data(o0d_l),
    .out1_valid(o1v_l), .out1_ready(out1_ready), .out1_data(o1d_l)
  );

  switch_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .s(s), .d(d),
    .out0_valid(o0v_m), .out0_ready(out0_ready), .out0_data(o0d_m),
    .out1_valid(o1v_m), .out1_ready(out1_ready), .out1_data(o1d_m)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare a presented word with the head of its lane queue; pop only when it is consumed.
  task automatic mon(input int k, input logic v, input logic r, input logic [3:0] dat);
    logic [3:0] exp;
    int         n;
    string      nm;
    if (v !== 1'b1) return;
    case (k)
      0: begin n = q0l.size(); nm = "lsb_ch0_word"; end
      1: begin n = q1l.size(); nm = "lsb_ch1_word"; end
      2: begin n = q0m.size(); nm = "msb_ch0_word"; end
      default: begin n = q1m.size(); nm = "msb_ch1_word"; end
    endcase
    if (n == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected word %b, none expected (t=%0t)", nm, dat, $time);
      return;
    end
    case (k)
      0: exp = r ? q0l.pop_front() : q0l[0];
      1: exp = r ? q1l.pop_front() : q1l[0];
      2: exp = r ? q0m.pop_front() : q0m[0];
      default: exp = r ? q1m.pop_front() : q1m[0];
    endcase
    chk(nm, {28'd0, dat}, {28'd0, exp});
  endtask

  // Scoreboard monitor: every valid output cycle is checked against the queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon(0, o0v_l, out0_ready, o0d_l);
      mon(1, o1v_l, out1_ready, o1d_l);
      mon(2, o0v_m, out0_ready, o0d_m);
      mon(3, o1v_m, out1_ready, o1d_m);
    end
  end

  task automatic push(input logic [3:0] l0, input logic [3:0] m0, input bit ch);
    if (ch) begin q1l.push_back(l0); q1m.push_back(m0); end
    else    begin q0l.push_back(l0); q0m.push_back(m0); end
  endtask

  // Present one bit and expect it to be accepted on the next edge.
  task automatic send_bit(input logic sel, input logic bit_d);
    in_valid = 1'b1;
    s        = sel;
    d        = bit_d;
    @(negedge clk);
    chk("in_ready_lsb", {31'd0, in_ready_l}, 32'd1);
    chk("in_ready_msb", {31'd0, in_ready_m}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_valids(input string name, input logic v0, input logic v1);
    chk({name, "_lsb_v0"}, {31'd0, o0v_l}, {31'd0, v0});
    chk({name, "_msb_v0"}, {31'd0, o0v_m}, {31'd0, v0});
    chk({name, "_lsb_v1"}, {31'd0, o1v_l}, {31'd0, v1});
    chk({name, "_msb_v1"}, {31'd0, o1v_m}, {31'd0, v1});
  endtask

  task automatic chk_reset_state(input string name);
    chk_valids(name, 1'b0, 1'b0);
    chk({name, "_lsb_d0"}, {28'd0, o0d_l}, 32'd0);
    chk({name, "_lsb_d1"}, {28'd0, o1d_l}, 32'd0);
    chk({name, "_msb_d0"}, {28'd0, o0d_m}, 32'd0);
    chk({name, "_msb_d1"}, {28'd0, o1d_m}, 32'd0);
    chk({name, "_in_ready"}, {31'd0, in_ready_l}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:11] stream;
    logic [0:3]  gap_bits;

    rst        = 1'b1;
    in_valid   = 1'b0;
    s          = 1'b0;
    d          = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk);
    #1;

    // Fill channel 0 with 1,0,1,1: LSB 1101, MSB 1011; valid for exactly one cycle.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    push(4'b1101, 4'b1011, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk_valids("fill_word", 1'b1, 1'b0);
    @(negedge clk);
    chk_valids("fill_after", 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Interleave: ch0 1,0,0,1 and ch1 0,1,1,1, both held until the 8th bit.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    push(4'b1001, 4'b1001, 1'b0);
    push(4'b1110, 4'b0111, 1'b1);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk_valids("interleave", 1'b1, 1'b1);
    @(posedge clk);
    #1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    idle(3);

    // Back-pressure on channel 1 while channel 0 keeps flowing.
    out1_ready = 1'b0;
    push(4'b0011, 4'b1100, 1'b1);
    push(4'b0101, 4'b1010, 1'b1);
    push(4'b0110, 4'b0110, 1'b0);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    in_valid = 1'b1;
    s        = 1'b1;
    d        = 1'b0;
    @(negedge clk);
    chk("stall_in_ready_lsb", {31'd0, in_ready_l}, 32'd0);
    chk("stall_in_ready_msb", {31'd0, in_ready_m}, 32'd0);
    chk("stall_v1", {31'd0, o1v_l}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall2_in_ready_lsb", {31'd0, in_ready_l}, 32'd0);
    chk("stall2_in_ready_msb", {31'd0, in_ready_m}, 32'd0);
    @(posedge clk);
    #1;
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    in_valid = 1'b1;
    s        = 1'b1;
    d        = 1'b0;
    @(negedge clk);
    chk("stall3_in_ready", {31'd0, in_ready_l}, 32'd0);
    @(posedge clk);
    #1;
    out1_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready_lsb", {31'd0, in_ready_l}, 32'd1);
    chk("release_in_ready_msb", {31'd0, in_ready_m}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("reload_v1_lsb", {31'd0, o1v_l}, 32'd1);
    chk("reload_v1_msb", {31'd0, o1v_m}, 32'd1);
    @(posedge clk);
    #1;
    idle(3);

    // Full throughput: 12 back-to-back bits on channel 0 give three words.
    push(4'b1111, 4'b1111, 1'b0);
    push(4'b1000, 4'b0001, 1'b0);
    push(4'b0001, 4'b1000, 1'b0);
    stream = 12'b1111_0001_1000;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      s        = 1'b0;
      d        = stream[i];
      @(negedge clk);
      chk("stream_in_ready", {31'd0, in_ready_l & in_ready_m}, 32'd1);
      chk("stream_v0_lsb", {31'd0, o0v_l}, {31'd0, (i == 4 || i == 8)});
      chk("stream_v0_msb", {31'd0, o0v_m}, {31'd0, (i == 4 || i == 8)});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_v0", {31'd0, o0v_l & o0v_m}, 32'd1);
    @(negedge clk);
    chk("stream_drained_v0", {31'd0, o0v_l | o0v_m}, 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-word: partial bits must not leak into the next word.
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("midreset");
    @(posedge clk);
    #1;
    push(4'b0100, 4'b0010, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    idle(3);

    // Idle gaps with d and s wiggling while in_valid is low.
    push(4'b0011, 4'b1100, 1'b0);
    gap_bits = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b0, gap_bits[i]);
      in_valid = 1'b0;
      for (int j = 0; j < 2; j++) begin
        d = ~d;
        s = ~s;
        @(posedge clk);
        #1;
      end
    end
    idle(4);

    chk("q0l_empty", q0l.size(), 32'd0);
    chk("q1l_empty", q1l.size(), 32'd0);
    chk("q0m_empty", q0m.size(), 32'd0);
    chk("q1m_empty", q1m.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_deserializer.md
Name: switch_deserializer

Overview:
- Downstream consumer of the 1-bit data/select switch stage.
- Takes a strobed serial bit stream and, using the same select, routes each bit to channel 0 (s=0) or channel 1 (s=1).
- Packs each channel's bits into WIDTH-bit words and presents each word on a per-channel valid/ready output.
- Gives the two switch outputs a word-level, back-pressured interface for the register/RAM stages that follow.

Parameters:
- WIDTH, 16: bits per assembled word; legal range 2..32.
- MSB_FIRST, 0: 0 = first accepted bit lands in bit 0; 1 = first accepted bit lands in bit WIDTH-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  source presents a bit this cycle.
- in_ready  output  1  bit accepted this cycle when in_valid & in_ready.
- s  input  1  channel select (0 -> channel 0, 1 -> channel 1).
- d  input  1  data bit.
- out0_valid  output  1  channel 0 word available.
- out0_ready  input  1  channel 0 consumer takes word.
- out0_data  output  WIDTH  channel 0 word.
- out1_valid  output  1  channel 1 word available.
- out1_ready  input  1  channel 1 consumer takes word.
- out1_data  output  WIDTH  channel 1 word.

Behaviour:
- Reset (rst=1 at a rising edge), including mid-word:
  - out0_valid=0, out1_valid=0; out0_data and out1_data = 0.
  - Both bit counters = 0; both assembly registers = 0.
  - Partial words are discarded.
- Per-channel state:
  - Assembly shift register (WIDTH-1 bits used).
  - Bit counter cnt, 0..WIDTH-1.
  - Holding register driving outN_data.
  - outN_valid flag.
- Routing: an accepted bit updates only the channel chosen by s; the other channel's assembly state is unchanged.
- Non-final bit (cnt < WIDTH-1):
  - Bit stored at position cnt (LSB-first) or WIDTH-1-cnt (MSB-first).
  - cnt increments.
  - Always acceptable.
- Final bit (cnt == WIDTH-1):
  - Full word (stored bits + this bit) loads the holding register.
  - outN_valid = 1 on the next cycle; cnt wraps to 0; assembly register clears.
  - Latency: word visible on the cycle after the WIDTH-th accepted bit.
- Channel can-accept: canN = !(cntN==WIDTH-1 && outN_valid && !outN_ready).
- in_ready = s ? can1 : can0.
  - Combinational from s, state and outN_ready; no combinational path from in_valid or d.
- in_valid=1 with in_ready=0: no state change. Source holds s and d until accepted.
- Output handshake:
  - outN_valid && outN_ready at an edge -> outN_valid clears, unless a new word loads on that same edge.
  - Same-edge drain and load: holding register takes the new word and outN_valid stays 1 (full throughput, one word per WIDTH bits).
- outN_data is stable while outN_valid=1 and not yet accepted. It holds its last value after being drained.
- Channels drain independently; a stalled channel 1 never blocks bits routed to channel 0.
- in_valid=0: counters, assembly and holding registers unchanged; output handshakes still proceed.
- s toggling every cycle is legal; bits interleave across channels with no loss.

Decomposition:
- Shared package (nandgame_pkg):
  - Localparams CH0=1'b0, CH1=1'b1.
  - DEFAULT_WORD_WIDTH=16.
  - Function clog2 for the counter width.
- One natural sub-module, switch_deser_channel (counter, assembly register, holding register, valid flag, can-accept), instantiated twice.
- Top level holds only the select decode (bit strobe to channel s) and the in_ready mux.

Test Plan:
- Fill channel 0 (WIDTH=4, LSB-first): reset, then s=0 with d=1,0,1,1 on 4 consecutive cycles, out0_ready=1 -> out0_valid=1 for exactly one cycle, the cycle after the 4th bit; out0_data=4'b1101; out1_valid stays 0.
- Interleaved channels (WIDTH=4, MSB-first): alternate s=0/1 for 8 cycles, channel 0 bits 1,0,0,1 and channel 1 bits 0,1,1,1 -> out0_data=4'b1001 and out1_data=4'b0111, both valid after the 8th accepted bit.
- Back-pressure: channel 1 holds one word with out1_ready=0; feed 3 more s=1 bits, then present a 4th -> in_ready=0 and nothing changes. Raise out1_ready -> 4th bit accepted on that edge, new word loaded, out1_valid stays 1. Meanwhile s=0 bits are accepted throughout the stall.
- Full throughput: continuous s=0 stream of 12 bits with out0_ready=1 -> 3 words, each valid exactly 1 cycle after its final bit; in_ready never drops.
- Reset mid-word: 2 bits into channel 0 then rst=1 for one cycle -> all outputs 0. A following 4-bit word 0,0,1,0 (LSB-first) yields out0_data=4'b0100, with no stale bits.
- Idle gaps: the 4 bits of a word spread with in_valid=0 cycles between them, and d toggling while in_valid=0 -> word equals only the accepted bits.
